// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: state encodings,
// default payload width and ID/EX payload field offsets.
package pipe_pkg;

    // Stage occupancy states; FULL aliases ONE in the single-register build
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } state_e;

    localparam state_e ST_FULL = ST_ONE;

    localparam int unsigned REG_W    = 32;
    localparam int unsigned REGIDX_W = 5;

    // PC, PCPlus4, RD1, RD2, ImmExt (5x32) plus Rs1, Rs2, Rd (3x5)
    localparam int unsigned PAYLOAD_W_DEF = 5 * REG_W + 3 * REGIDX_W;

    // ID/EX field LSB offsets, packed {PC, PCPlus4, RD1, RD2, ImmExt, Rs1, Rs2, Rd}
    localparam int unsigned IDEX_RD_LSB   = 0;
    localparam int unsigned IDEX_RS2_LSB  = IDEX_RD_LSB  + REGIDX_W;
    localparam int unsigned IDEX_RS1_LSB  = IDEX_RS2_LSB + REGIDX_W;
    localparam int unsigned IDEX_IMM_LSB  = IDEX_RS1_LSB + REGIDX_W;
    localparam int unsigned IDEX_RD2_LSB  = IDEX_IMM_LSB + REG_W;
    localparam int unsigned IDEX_RD1_LSB  = IDEX_RD2_LSB + REG_W;
    localparam int unsigned IDEX_PCP4_LSB = IDEX_RD1_LSB + REG_W;
    localparam int unsigned IDEX_PC_LSB   = IDEX_PCP4_LSB + REG_W;

endpackage

// File: rtl/pipe_skid_buf.sv
// Skid entry of the 2-deep pipeline stage: one payload register plus its
// valid bit. Loaded when the main register is blocked, drained into main.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned PAYLOAD_W      = PAYLOAD_W_DEF,
    parameter int unsigned CLEAR_ON_FLUSH = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush_i,
    input  logic                 load_i,
    input  logic                 drain_i,
    input  logic [PAYLOAD_W-1:0] data_i,
    output logic [PAYLOAD_W-1:0] data_o,
    output logic                 valid_o
);

    logic [PAYLOAD_W-1:0] data_q;
    logic                 vld_q;

    // Skid entry storage: reset and flush dominate load/drain
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (flush_i) begin
            vld_q <= 1'b0;
            if (CLEAR_ON_FLUSH != 0) begin
                data_q <= '0;
            end
        end else if (load_i) begin
            vld_q  <= 1'b1;
            data_q <= data_i;
        end else if (drain_i) begin
            vld_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = vld_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush and stall counter.
// Define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with a registered
// in_ready_o; otherwise a single register with combinational in_ready_o.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned PAYLOAD_W      = PAYLOAD_W_DEF,
    parameter int unsigned CLEAR_ON_FLUSH = 1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [PAYLOAD_W-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [PAYLOAD_W-1:0] out_data_o,
    output logic [CNT_W-1:0]     stall_cnt_o
);

    state_e               state_q;
    logic                 main_vld_q;
    logic [PAYLOAD_W-1:0] main_data_q;
    logic [CNT_W-1:0]     stall_cnt_q;
    logic [CNT_W-1:0]     stall_cnt_d;
    logic                 accept;
    logic                 deliver;

    assign accept  = in_valid_i & in_ready_o;
    assign deliver = main_vld_q & out_ready_i;

`ifdef PIPE_STAGE_SKID_EN
    logic                 ready_q;
    logic                 skid_vld;
    logic                 skid_load;
    logic                 skid_drain;
    logic [PAYLOAD_W-1:0] skid_data;

    assign in_ready_o = ready_q;
    assign skid_load  = !flush_i && (state_q == ST_ONE) && accept && !deliver;
    assign skid_drain = !flush_i && (state_q == ST_TWO) && deliver && skid_vld;

    pipe_skid_buf #(
        .PAYLOAD_W      (PAYLOAD_W),
        .CLEAR_ON_FLUSH (CLEAR_ON_FLUSH)
    ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .flush_i (flush_i),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .data_i  (in_data_i),
        .data_o  (skid_data),
        .valid_o (skid_vld)
    );

    // EMPTY/ONE/TWO occupancy FSM owning the main register and ready flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_EMPTY;
            main_vld_q  <= 1'b0;
            main_data_q <= '0;
            ready_q     <= 1'b1;
        end else if (flush_i) begin
            state_q    <= ST_EMPTY;
            main_vld_q <= 1'b0;
            ready_q    <= 1'b1;
            if (CLEAR_ON_FLUSH != 0) begin
                main_data_q <= '0;
            end
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_data_q <= in_data_i;
                        main_vld_q  <= 1'b1;
                        state_q     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && deliver) begin
                        main_data_q <= in_data_i;
                    end else if (accept) begin
                        state_q <= ST_TWO;
                        ready_q <= 1'b0;
                    end else if (deliver) begin
                        main_vld_q <= 1'b0;
                        state_q    <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (deliver) begin
                        main_data_q <= skid_data;
                        state_q     <= ST_ONE;
                        ready_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_EMPTY;
                    main_vld_q <= 1'b0;
                    ready_q    <= 1'b1;
                end
            endcase
        end
    end
`else
    assign in_ready_o = !main_vld_q | out_ready_i;

    // EMPTY/FULL FSM owning the single payload register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_EMPTY;
            main_vld_q  <= 1'b0;
            main_data_q <= '0;
        end else if (flush_i) begin
            state_q    <= ST_EMPTY;
            main_vld_q <= 1'b0;
            if (CLEAR_ON_FLUSH != 0) begin
                main_data_q <= '0;
            end
        end else begin
            unique case (state_q)
                ST_EMPTY, ST_FULL: begin
                    if (accept) begin
                        main_data_q <= in_data_i;
                        main_vld_q  <= 1'b1;
                        state_q     <= ST_FULL;
                    end else if (deliver) begin
                        main_vld_q <= 1'b0;
                        state_q    <= ST_EMPTY;
                    end
                end
                default: begin
                    state_q    <= ST_EMPTY;
                    main_vld_q <= 1'b0;
                end
            endcase
        end
    end
`endif

    // Saturating count of back-pressured cycles; flush does not stop it
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_vld_q && !out_ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register, cleared only by reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid_o = main_vld_q;
    assign out_data_o  = main_data_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 175, meaning the payload width in bits. The default is PC, PCPlus4, RD1, RD2 and ImmExt (5x32), plus Rs1, Rs2 and Rd (3x5).
REQ-002 SHALL have parameter CLEAR_ON_FLUSH, default 1, meaning flush zeroes the stored payload (1) or leaves it unchanged (0).
REQ-003 SHALL have parameter CNT_W, default 16, meaning the stall-counter width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port flush_i, input, 1 bit: synchronous pipeline flush (bubble insertion).
REQ-007 SHALL have port in_valid_i, input, 1 bit: upstream offers a payload.
REQ-008 SHALL have port in_ready_o, output, 1 bit: stage can accept a payload.
REQ-009 SHALL have port in_data_i, input, PAYLOAD_W bits: upstream payload.
REQ-010 SHALL have port out_valid_o, output, 1 bit: stage holds a payload for downstream.
REQ-011 SHALL have port out_ready_i, input, 1 bit: downstream accepts this cycle.
REQ-012 SHALL have port out_data_o, output, PAYLOAD_W bits: head payload.
REQ-013 SHALL have port stall_cnt_o, output, CNT_W bits: count of back-pressured cycles.

Function
REQ-014 Accept SHALL occur when in_valid_i and in_ready_o are both high at a rising edge; deliver SHALL occur when out_valid_o and out_ready_i are both high at a rising edge.
REQ-015 Latency SHALL be exactly 1 cycle: data accepted at edge N appears on out_data_o, with out_valid_o high, after edge N.
REQ-016 Payloads SHALL leave in acceptance order; none SHALL be lost or duplicated while flush_i is low.
REQ-017 Simultaneous accept and deliver SHALL be supported every cycle, giving full throughput of 1 payload per cycle.
REQ-018 out_valid_o and out_data_o SHALL NOT change while out_valid_o is high and out_ready_i is low.
REQ-019 On flush_i high, every valid bit SHALL clear at the next edge; any accept that cycle SHALL be discarded. Stored payloads SHALL be zeroed when CLEAR_ON_FLUSH=1 and left unchanged otherwise.
REQ-020 flush_i SHALL take priority over accept and deliver; the stall counter SHALL still update during flush.
REQ-021 stall_cnt_o SHALL increment on every edge where out_valid_o is high and out_ready_i is low, saturate at 2^CNT_W-1, and be cleared only by reset.
REQ-022 in_valid_i SHALL be ignored while in_ready_o is low.

Reset
REQ-023 When reset_n is low at an edge, the following SHALL be forced: out_valid_o=0, out_data_o=0, every internal valid bit and payload to 0, stall_cnt_o=0, state EMPTY.
REQ-024 Reset SHALL take priority over flush_i and all handshakes, including when asserted mid-stall with a full buffer.
REQ-025 In the cycle after reset_n is released, in_ready_o SHALL be 1.

Configuration
REQ-026 Macro PIPE_STAGE_SKID_EN SHALL select a 2-entry skid buffer: a main register plus a skid register, with FSM states EMPTY, ONE and TWO.
  - EMPTY->ONE on accept.
  - ONE->TWO on accept without deliver.
  - ONE->EMPTY on deliver without accept.
  - TWO->ONE on deliver; the skid entry moves to main.
  - in_ready_o SHALL be driven directly by a register: 1 exactly when the state is not TWO.
REQ-027 Without PIPE_STAGE_SKID_EN, the block SHALL be a single register with states EMPTY and FULL. in_ready_o SHALL be combinational: in_ready_o = !out_valid_o | out_ready_i.

Structure
REQ-028 A shared package pipe_pkg SHALL hold:
  - the state encodings (EMPTY=2'b00, ONE/FULL=2'b01, TWO=2'b10);
  - the default PAYLOAD_W constant;
  - the ID/EX payload field offsets.
REQ-029 Sub-module pipe_skid_buf SHALL hold the skid register and its valid bit, and SHALL be instantiated only under PIPE_STAGE_SKID_EN.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
  - Reset: reset_n=0 for 2 cycles -> out_valid_o=0, out_data_o=0, stall_cnt_o=0; in_ready_o=1 the cycle after release.
  - Streaming: in_valid_i=1 for 8 cycles with data 1..8, out_ready_i=1 -> out_data_o shows 1..8 on consecutive cycles, 1 cycle behind the input.
  - Back-pressure: load 0xA5 with out_ready_i=0 for 5 cycles -> 0xA5 held, stall_cnt_o=5. With skid enabled, a second word 0xB6 is accepted and in_ready_o then drops to 0.
  - Flush: flush_i=1 while holding 0x3C, with in_valid_i=1 and data 0x77 -> next cycle out_valid_o=0, out_data_o=0 (CLEAR_ON_FLUSH=1), and 0x77 is never delivered.
  - Saturation: CNT_W=4, stall for 20 cycles -> stall_cnt_o=15.
  - Reset mid-stall: skid full (0x11, 0x22), reset_n=0 -> state EMPTY, both entries dropped, stall_cnt_o=0.
